// File: rtl/ppu_scheduler.sv
// ppu_scheduler: round-robin arbiter of two byte sources onto the PPU stb/ack channel,
// plus the sync-aligned PPU mode register with optional auto-cycling.
module ppu_scheduler #(
    parameter int TIMEOUT         = 64,
    parameter int FRAMES_PER_MODE = 120,
    parameter int MODE_MAX        = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sync,
    input  logic [7:0] a_data,
    input  logic       a_stb,
    output logic       a_ack,
    input  logic [7:0] b_data,
    input  logic       b_stb,
    output logic       b_ack,
    output logic [7:0] ppu_data,
    output logic       ppu_stb,
    input  logic       ppu_ack,
    input  logic [2:0] mode_req,
    input  logic       mode_req_vld,
    input  logic       auto_cycle,
    output logic [2:0] mode,
    output logic       timeout_err
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int FW = $clog2(FRAMES_PER_MODE + 1);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t        state;
    logic          grant_b;
    logic          last_b;
    logic          pick_b;
    logic          req_ok;
    logic [TW-1:0] tmo_cnt;
    logic [FW-1:0] frame_cnt;
    logic [2:0]    pending;
    logic          pending_vld;

    // B wins only when A is absent or A was served last
    always_comb pick_b = b_stb && (!a_stb || !last_b);
    always_comb req_ok = mode_req_vld && (mode_req <= 3'(MODE_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            grant_b     <= 1'b0;
            last_b      <= 1'b1;
            tmo_cnt     <= '0;
            ppu_data    <= '0;
            ppu_stb     <= 1'b0;
            a_ack       <= 1'b0;
            b_ack       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            case (state)
                IDLE: if (a_stb || b_stb) begin
                    grant_b  <= pick_b;
                    ppu_data <= pick_b ? b_data : a_data;
                    ppu_stb  <= 1'b1;
                    tmo_cnt  <= '0;
                    state    <= SEND;
                end
                SEND: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    // ack in the timeout cycle counts as delivery, not an error
                    if (ppu_ack || tmo_cnt == TW'(TIMEOUT - 1)) begin
                        ppu_stb     <= 1'b0;
                        a_ack       <= !grant_b;
                        b_ack       <= grant_b;
                        last_b      <= grant_b;
                        timeout_err <= timeout_err | !ppu_ack;
                        state       <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode        <= '0;
            pending     <= '0;
            pending_vld <= 1'b0;
            frame_cnt   <= '0;
        end else if (sync && (req_ok || pending_vld)) begin
            mode        <= req_ok ? mode_req : pending;
            pending_vld <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            if (req_ok) begin
                pending     <= mode_req;
                pending_vld <= 1'b1;
            end
            if (sync && auto_cycle) begin
                if (frame_cnt == FW'(FRAMES_PER_MODE - 1)) begin
                    mode      <= (mode == 3'(MODE_MAX)) ? 3'd0 : mode + 3'd1;
                    frame_cnt <= '0;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ppu_scheduler.sv
// tb_ppu_scheduler: scoreboard bench for ppu_scheduler; expected grants are queued by the
// stimulus and checked by an independent monitor on every source ack.
module tb_ppu_scheduler;
    logic       clk = 0, rst = 1, sync = 0;
    logic [7:0] a_data = 0, b_data = 0, ppu_data;
    logic       a_stb = 0, b_stb = 0, a_ack, b_ack, ppu_stb, ppu_ack = 0;
    logic [2:0] mode_req = 0, mode;
    logic       mode_req_vld = 0, auto_cycle = 0, timeout_err;
    logic       ppu_en = 1;
    int         n_cmp = 0, n_err = 0;

    typedef struct {logic src; logic [7:0] data; int len;} txn_t;
    txn_t       sb[$];
    logic [7:0] a_bytes[$], b_bytes[$];

    ppu_scheduler #(.TIMEOUT(64), .FRAMES_PER_MODE(2), .MODE_MAX(5)) dut (
        .clk(clk), .rst(rst), .sync(sync),
        .a_data(a_data), .a_stb(a_stb), .a_ack(a_ack),
        .b_data(b_data), .b_stb(b_stb), .b_ack(b_ack),
        .ppu_data(ppu_data), .ppu_stb(ppu_stb), .ppu_ack(ppu_ack),
        .mode_req(mode_req), .mode_req_vld(mode_req_vld), .auto_cycle(auto_cycle),
        .mode(mode), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // PPU model: acks during the second cycle of a strobe
    initial begin
        int pcnt = 0;
        forever begin
            @(negedge clk);
            pcnt = ppu_stb ? pcnt + 1 : 0;
            ppu_ack = ppu_en && pcnt >= 2;
        end
    end

    // Requesters: on ack, present the next queued byte or drop stb
    initial forever begin
        @(negedge clk);
        if (a_ack) begin
            void'(a_bytes.pop_front());
            if (a_bytes.size() > 0) a_data = a_bytes[0]; else a_stb = 0;
        end
        if (b_ack) begin
            void'(b_bytes.pop_front());
            if (b_bytes.size() > 0) b_data = b_bytes[0]; else b_stb = 0;
        end
    end

    // Monitor: data at strobe rise, source and strobe length at each ack
    initial begin
        logic prev = 0;
        int   len = 0;
        txn_t t;
        forever begin
            @(negedge clk);
            if (ppu_stb && !prev) begin
                len = 0;
                if (sb.size() > 0) chk("ppu_data", ppu_data, sb[0].data);
            end
            if (ppu_stb) len++;
            if (a_ack || b_ack) begin
                chk("single_ack", a_ack && b_ack, 0);
                if (sb.size() == 0) chk("unexpected_ack", {a_ack, b_ack}, 0);
                else begin
                    t = sb.pop_front();
                    chk("ack_src", b_ack, t.src);
                    chk("stb_len", len, t.len);
                end
            end
            prev = ppu_stb;
        end
    end

    task automatic wait_done(input string name);
        for (int i = 0; i < 400 && (sb.size() > 0 || a_stb || b_stb); i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk(name, sb.size(), 0);
    endtask

    task automatic req(input logic [2:0] m, input logic with_sync);
        @(negedge clk);
        mode_req = m; mode_req_vld = 1; sync = with_sync;
        @(negedge clk);
        mode_req_vld = 0; sync = 0;
    endtask

    task automatic do_sync();
        @(negedge clk); sync = 1;
        @(negedge clk); sync = 0;
    endtask

    initial begin
        #1;
        chk("rst_ppu_stb", ppu_stb, 0);
        chk("rst_ppu_data", ppu_data, 0);
        chk("rst_acks", {a_ack, b_ack}, 0);
        chk("rst_mode", mode, 0);
        chk("rst_terr", timeout_err, 0);
        repeat (2) @(negedge clk);
        rst = 0;

        // single source
        a_bytes = '{8'h5A}; a_data = 8'h5A; a_stb = 1;
        sb.push_back('{1'b0, 8'h5A, 2});
        wait_done("single_drain");
        chk("single_terr", timeout_err, 0);

        // timeout on B
        ppu_en = 0;
        b_bytes = '{8'h3C}; b_data = 8'h3C; b_stb = 1;
        sb.push_back('{1'b1, 8'h3C, 64});
        wait_done("timeout_drain");
        chk("timeout_terr", timeout_err, 1);
        ppu_en = 1;

        // contention: last grant was B, so A leads
        a_bytes = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        b_bytes = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{1'b0, a_bytes[i], 2});
            sb.push_back('{1'b1, b_bytes[i], 2});
        end
        @(negedge clk);
        a_data = 8'hA0; b_data = 8'hB0; a_stb = 1; b_stb = 1;
        wait_done("contend_drain");
        chk("terr_sticky", timeout_err, 1);

        // mode requests
        req(3'd3, 0);
        repeat (3) @(negedge clk);
        chk("mode_hold_3", mode, 0);
        req(3'd4, 0);
        req(3'd7, 0);
        chk("mode_hold_4", mode, 0);
        do_sync();
        chk("mode_4", mode, 4);
        req(3'd7, 0);
        do_sync();
        chk("mode_7_ignored", mode, 4);
        req(3'd2, 1);
        chk("mode_same_cycle", mode, 2);

        // auto-cycle with FRAMES_PER_MODE=2
        req(3'd5, 0);
        do_sync();
        chk("mode_5", mode, 5);
        auto_cycle = 1;
        do_sync();
        chk("auto_1sync", mode, 5);
        do_sync();
        chk("auto_wrap", mode, 0);
        do_sync();
        do_sync();
        chk("auto_step", mode, 1);
        auto_cycle = 0;
        repeat (3) do_sync();
        chk("auto_frozen", mode, 1);

        // async reset while A is in SEND
        ppu_en = 0;
        a_bytes = '{8'h77}; a_data = 8'h77; a_stb = 1;
        repeat (4) @(negedge clk);
        chk("pre_rst_stb", ppu_stb, 1);
        #1 rst = 1;
        #1;
        chk("rst_async_stb", ppu_stb, 0);
        chk("rst_async_mode", mode, 0);
        chk("rst_async_terr", timeout_err, 0);
        repeat (2) @(negedge clk);
        ppu_en = 1;
        b_bytes = '{8'h22}; b_data = 8'h22; b_stb = 1;
        sb.push_back('{1'b0, 8'h77, 2});
        sb.push_back('{1'b1, 8'h22, 2});
        rst = 0;
        wait_done("post_rst_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
